// File: rtl/framebuffer_fetch_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_fetch_arbiter_if
// Purpose  : Line-fetch, pixel-writer and framebuffer memory bus bundle.
// Revision : 1.0
// ============================================================================
interface framebuffer_fetch_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 3
);
  logic                  aLineRequest;
  logic [8:0]            aLineY;
  logic                  anOutLineBusy;
  logic                  anOutLineDone;
  logic                  anOutLineWriteEnable;
  logic [8:0]            anOutLineWriteX;
  logic [DATA_WIDTH-1:0] anOutLineWriteData;
  logic                  aWriteValid;
  logic [8:0]            aWriteX;
  logic [8:0]            aWriteY;
  logic [DATA_WIDTH-1:0] aWriteData;
  logic                  anOutWriteReady;
  logic [ADDR_WIDTH-1:0] anOutMemAddress;
  logic                  anOutMemWriteEnable;
  logic [DATA_WIDTH-1:0] anOutMemWriteData;
  logic [DATA_WIDTH-1:0] aMemReadData;
  logic                  anOutError;

  // Environment side: display prefetcher, pixel writer and framebuffer RAM.
  modport master (
    output aLineRequest, aLineY, aWriteValid, aWriteX, aWriteY, aWriteData, aMemReadData,
    input  anOutLineBusy, anOutLineDone, anOutLineWriteEnable, anOutLineWriteX,
           anOutLineWriteData, anOutWriteReady, anOutMemAddress, anOutMemWriteEnable,
           anOutMemWriteData, anOutError
  );

  modport slave (
    input  aLineRequest, aLineY, aWriteValid, aWriteX, aWriteY, aWriteData, aMemReadData,
    output anOutLineBusy, anOutLineDone, anOutLineWriteEnable, anOutLineWriteX,
           anOutLineWriteData, anOutWriteReady, anOutMemAddress, anOutMemWriteEnable,
           anOutMemWriteData, anOutError
  );
endinterface
`default_nettype wire

// File: rtl/framebuffer_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_fetch_arbiter
// Purpose  : Shares the single-port framebuffer between display row fetches
//            (priority) and single-pixel writes.
// Revision : 1.0
// ============================================================================
module framebuffer_fetch_arbiter #(
  parameter int MEM_WIDTH  = 320,
  parameter int MEM_HEIGHT = 240,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 3
) (
  input  logic                        aClock,
  input  logic                        aReset,
  framebuffer_fetch_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_row_stride = ADDR_WIDTH'(MEM_WIDTH);
  localparam logic [8:0]            c_last_x     = 9'(MEM_WIDTH - 1);
  localparam logic [9:0]            c_width      = 10'(MEM_WIDTH);
  localparam logic [9:0]            c_height     = 10'(MEM_HEIGHT);

  state_t                r_state;
  logic [8:0]            r_x;
  logic                  r_busy;
  logic                  r_line_done;
  logic                  r_line_we;
  logic [8:0]            r_line_x;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_wd;
  logic                  r_error;

  logic                  w_line_y_ok;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_pix_ok;
  logic [ADDR_WIDTH-1:0] w_line_base;
  logic [ADDR_WIDTH-1:0] w_pix_addr;

  assign w_line_y_ok = {1'b0, bus.aLineY} < c_height;
  // Ready drops combinationally on a line request so the fetch always wins.
  assign w_ready     = (r_state == S_IDLE) && !bus.aLineRequest && !aReset;
  assign w_accept    = bus.aWriteValid && w_ready;
  assign w_pix_ok    = ({1'b0, bus.aWriteX} < c_width) && ({1'b0, bus.aWriteY} < c_height);
  assign w_line_base = ADDR_WIDTH'(bus.aLineY) * c_row_stride;
  assign w_pix_addr  = ADDR_WIDTH'(bus.aWriteY) * c_row_stride + ADDR_WIDTH'(bus.aWriteX);

  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_busy      <= 1'b0;
      r_line_done <= 1'b0;
      r_line_we   <= 1'b0;
      r_line_x    <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wd    <= '0;
      r_error     <= 1'b0;
    end else begin
      r_line_done <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wd    <= '0;
      case (r_state)
        S_IDLE: begin
          r_line_we <= 1'b0;
          r_line_x  <= '0;
          if (bus.aLineRequest) begin
            if (w_line_y_ok) begin
              r_state    <= S_FETCH;
              r_x        <= '0;
              r_busy     <= 1'b1;
              r_mem_addr <= w_line_base;
            end else begin
              r_error <= 1'b1;
            end
          end else if (w_accept && w_pix_ok) begin
            // Out-of-range pixels complete the handshake but never reach memory.
            r_mem_we   <= 1'b1;
            r_mem_addr <= w_pix_addr;
            r_mem_wd   <= bus.aWriteData;
          end
        end
        S_FETCH: begin
          if (bus.aLineRequest) r_error <= 1'b1;
          r_line_we <= 1'b1;
          r_line_x  <= r_x;
          if (r_x == c_last_x) begin
            r_state     <= S_DRAIN;
            r_line_done <= 1'b1;
          end else begin
            r_x        <= r_x + 9'd1;
            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (bus.aLineRequest) r_error <= 1'b1;
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_x       <= '0;
          r_line_we <= 1'b0;
          r_line_x  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.anOutLineBusy        = r_busy;
  assign bus.anOutLineDone        = r_line_done;
  assign bus.anOutLineWriteEnable = r_line_we;
  assign bus.anOutLineWriteX      = r_line_x;
  // Read data lands one cycle after its address, aligned with the delayed strobe.
  assign bus.anOutLineWriteData   = r_line_we ? bus.aMemReadData : '0;
  assign bus.anOutWriteReady      = w_ready;
  assign bus.anOutMemAddress      = r_mem_addr;
  assign bus.anOutMemWriteEnable  = r_mem_we;
  assign bus.anOutMemWriteData    = r_mem_wd;
  assign bus.anOutError           = r_error;

endmodule
`default_nettype wire

// File: doc/framebuffer_fetch_arbiter.md
# framebuffer_fetch_arbiter

Sequences and shares the single-port half-resolution framebuffer (MEM_WIDTH x MEM_HEIGHT palette IDs) between two requesters: the display scanline prefetcher and a pixel writer (CPU/rasterizer). On a line request it streams one full memory row into the display line buffer, which the Shaper/Depalettizer path then reads at X/2. Between fetches it grants single-pixel writes through a valid/ready handshake. Display fetch always has priority.

## Interface
- MEM_WIDTH, 320, pixels per framebuffer row
- MEM_HEIGHT, 240, framebuffer rows
- ADDR_WIDTH, 17, framebuffer address width (must hold MEM_WIDTH*MEM_HEIGHT-1)
- DATA_WIDTH, 3, palette ID width
- aClock  in  1  single clock; all state updates on rising edge
- aReset  in  1  asynchronous, active-high reset
- aLineRequest  in  1  one-cycle pulse: fetch row aLineY
- aLineY  in  9  row to fetch
- anOutLineBusy  out  1  fetch in progress
- anOutLineDone  out  1  one-cycle pulse, last pixel of row written
- anOutLineWriteEnable  out  1  line buffer write strobe
- anOutLineWriteX  out  9  line buffer write index
- anOutLineWriteData  out  DATA_WIDTH  line buffer write data
- aWriteValid  in  1  writer has a pixel
- aWriteX  in  9  pixel column
- aWriteY  in  9  pixel row
- aWriteData  in  DATA_WIDTH  pixel palette ID
- anOutWriteReady  out  1  pixel accepted when valid && ready
- anOutMemAddress  out  ADDR_WIDTH  framebuffer address
- anOutMemWriteEnable  out  1  framebuffer write strobe
- anOutMemWriteData  out  DATA_WIDTH  framebuffer write data
- aMemReadData  in  DATA_WIDTH  framebuffer read data, valid the cycle after its address
- anOutError  out  1  sticky: request dropped (busy or aLineY >= MEM_HEIGHT)

## Operation
- FSM: IDLE, FETCH, DRAIN. Reset -> IDLE.
- IDLE: on aLineRequest with aLineY < MEM_HEIGHT: latch rowBase = aLineY*MEM_WIDTH (ADDR_WIDTH bits, no overflow for legal rows), x = 0, -> FETCH.
- FETCH: anOutMemAddress = rowBase + x, anOutMemWriteEnable = 0; x increments each cycle; after issuing x = MEM_WIDTH-1 -> DRAIN.
- DRAIN: one cycle, no memory access; last read data written to line buffer; anOutLineDone = 1; -> IDLE.
- Line buffer path: valid and X delayed one cycle from issued read; anOutLineWriteData = aMemReadData (combinational); X = 0..MEM_WIDTH-1 in order, exactly once per fetch.
- Dropped requests: aLineRequest while not IDLE, or aLineY >= MEM_HEIGHT -> no fetch, anOutError set until reset.
- Writer: anOutWriteReady = (state == IDLE) && !aLineRequest && !aReset. Accepted pixel registered; next cycle anOutMemWriteEnable = 1, address = aWriteY*MEM_WIDTH + aWriteX, data = aWriteData.
- Out-of-range pixel (aWriteX >= MEM_WIDTH or aWriteY >= MEM_HEIGHT): accepted (handshake completes), discarded, no memory write, no error.
- IDLE with no pending write: anOutMemAddress = 0, anOutMemWriteEnable = 0.
- Simultaneous aLineRequest and aWriteValid in IDLE: fetch wins, ready = 0, writer holds.

## Timing
- Reset: state IDLE, x = 0, all outputs 0 (including anOutWriteReady and anOutError). Reset mid-fetch aborts immediately: no further line writes, no done pulse.
- Request sampled in cycle 0 -> reads issued cycles 1..MEM_WIDTH; line writes cycles 2..MEM_WIDTH+1 (X = cycle-2); anOutLineDone in cycle MEM_WIDTH+1.
- anOutLineBusy high cycles 1..MEM_WIDTH+1. Earliest accepted next request: cycle MEM_WIDTH+2.
- Write accepted cycle n -> memory write in cycle n+1; never overlaps a read (fetch reads start only after a cycle with ready = 0).
- Writer throughput in IDLE: one pixel per cycle. Writer stall per fetch: MEM_WIDTH+2 cycles (request cycle through DRAIN).

## Test plan
- Reset then row 0 request (MEM_WIDTH=320): reads addresses 0..319 in cycles 1..320; line writes X 0..319 with memory model data in cycles 2..321; done exactly in cycle 321; busy 1..321.
- Row 239 request: first address 76480, last 76799; anOutError stays 0.
- Writes (x=5,y=3,d=6) back-to-back with (x=319,y=239,d=1): mem writes at 965 and 76799 on consecutive cycles, ready held 1.
- aLineRequest and aWriteValid same cycle: ready 0, fetch runs; pending write accepted cycle MEM_WIDTH+2, mem write cycle MEM_WIDTH+3.
- Request during busy, and request with aLineY=240: no extra reads, anOutError = 1 sticky; out-of-range pixel (x=320): handshake completes, no mem write.
- Assert aReset at fetch cycle 100: all outputs 0 asynchronously, no done pulse; after release new row 5 request fetches addresses 1600..1919 normally.
